// File: rtl/monox_pkg.sv
// Shared definitions for the monox result drain.
//   state_t        : drain FSM states
//   N_EFF_HEADROOM : n_eff saturates at ADDR_WIDTH + N_EFF_HEADROOM (4 banks = 2 extra index bits)
//   sat_n()        : clamps a requested log2 length to what the banks can hold
//   calc_words()   : words per lane, W = max(1, (1 << n_eff) >> 2)
package monox_pkg;

   localparam int N_EFF_HEADROOM = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int sat_n(input int n, input int addr_width);
      return (n > addr_width + N_EFF_HEADROOM) ? addr_width + N_EFF_HEADROOM : n;
   endfunction

   function automatic int calc_words(input int n_eff);
      int w;
      w = (1 << n_eff) >> 2;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/monox_result_drain_if.sv
// Read port bundle for the yellow and green 4-bank result memories.
//   o_addr_y/g : per-lane bank addresses (lane k = [k*ADDR_WIDTH +: ADDR_WIDTH])
//   o_en_y/g   : bank read enables
//   i_data_y/g : bank read data, BRAM_READ_LATENCY cycles after the enable
// master = drain side, slave = memory side.
interface monox_result_drain_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12
);
   logic [4*ADDR_WIDTH-1:0] o_addr_y;
   logic [4*ADDR_WIDTH-1:0] o_addr_g;
   logic                    o_en_y;
   logic                    o_en_g;
   logic [4*DATA_WIDTH-1:0] i_data_y;
   logic [4*DATA_WIDTH-1:0] i_data_g;

   modport master (
      output o_addr_y, o_addr_g, o_en_y, o_en_g,
      input  i_data_y, i_data_g
   );

   modport slave (
      input  o_addr_y, o_addr_g, o_en_y, o_en_g,
      output i_data_y, i_data_g
   );
endinterface

// File: rtl/monox_valid_pipe.sv
// Enable-gated shift register tracking which cycles carry a BRAM read.
//   clk, rst : clock, asynchronous active-high reset
//   i_en     : advance enable; low holds every stage
//   i_bit    : bit entering stage 0
//   o_tail   : last stage (read data is valid at the memory output)
module monox_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_bit,
   output logic o_tail
);
   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   always_comb begin
      pipe_d = pipe_q;
      if (i_en) begin
         pipe_d[0] = i_bit;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
   end

   assign o_tail = pipe_q[DEPTH-1];
endmodule

// File: rtl/monox_result_drain.sv
// Reads the yellow and green result banks back in lockstep and streams them
// out as 4-lane beats for the next monox pass.
//   clk, rst    : clock, asynchronous active-high reset
//   i_en        : global enable; low freezes all state and masks o_en / o_valid
//   i_start     : start pulse, only looked at in IDLE
//   i_n         : log2 coefficient count, captured (saturated) on start
//   bram        : read port to both bank groups (master side)
//   o_data_y/g  : registered output beat
//   o_valid     : beat valid (no back-pressure: a beat is consumed in the cycle
//                 o_valid is high; it is never repeated or held for a consumer)
//   o_n         : captured n while busy, 0 in IDLE
//   o_done      : pulses with the final beat
//   o_dbg_state : current FSM state
module monox_result_drain
   import monox_pkg::*;
#(
   parameter int DATA_WIDTH        = 64,
   parameter int INDEX_WIDTH       = 13,
   parameter int ADDR_WIDTH        = INDEX_WIDTH - 1,
   parameter int BRAM_READ_LATENCY = 2,
   parameter int POWER_WIDTH       = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en,
   input  logic                    i_start,
   input  logic [POWER_WIDTH-1:0]  i_n,
   monox_result_drain_if.master    bram,
   output logic [4*DATA_WIDTH-1:0] o_data_y,
   output logic [4*DATA_WIDTH-1:0] o_data_g,
   output logic                    o_valid,
   output logic [POWER_WIDTH-1:0]  o_n,
   output logic                    o_done,
   output state_t                  o_dbg_state
);
   localparam int WW = ADDR_WIDTH + 1;

   state_t                  state_q, state_d;
   logic [POWER_WIDTH-1:0]  n_q, n_d;
   logic [WW-1:0]           words_q, words_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   beat_q, beat_d;
   logic [4*DATA_WIDTH-1:0] data_y_q, data_y_d;
   logic [4*DATA_WIDTH-1:0] data_g_q, data_g_d;
   logic                    valid_q, valid_d;

   logic                    rd_en;
   logic                    tail;
   logic                    beat_out;
   logic                    last_addr;
   logic                    last_beat;
   logic                    done;
   logic [POWER_WIDTH-1:0]  n_eff;

   assign n_eff     = POWER_WIDTH'(sat_n(int'(i_n), ADDR_WIDTH));
   assign rd_en     = i_en && (state_q == ST_READ);
   // The output register holds its beat across an i_en stall; it is only
   // presented (and counted) in enabled cycles.
   assign beat_out  = i_en && valid_q;
   assign last_addr = ({1'b0, addr_q} == (words_q - WW'(1)));
   assign last_beat = ({1'b0, beat_q} == (words_q - WW'(1)));
   assign done      = beat_out && last_beat;

   monox_valid_pipe #(
      .DEPTH (BRAM_READ_LATENCY)
   ) u_valid_pipe (
      .clk    (clk),
      .rst    (rst),
      .i_en   (i_en),
      .i_bit  (rd_en),
      .o_tail (tail)
   );

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      words_d  = words_q;
      addr_d   = addr_q;
      beat_d   = beat_q;
      data_y_d = data_y_q;
      data_g_d = data_g_q;
      valid_d  = valid_q;

      if (beat_out) beat_d = beat_q + 1'b1;

      // Memory output is only meaningful when the read it belongs to has
      // travelled the whole latency pipe.
      if (i_en) begin
         valid_d = tail;
         if (tail) begin
            data_y_d = bram.i_data_y;
            data_g_d = bram.i_data_g;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (i_start && i_en) begin
               n_d     = n_eff;
               words_d = WW'(calc_words(int'(n_eff)));
               addr_d  = '0;
               beat_d  = '0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (i_en) begin
               addr_d = addr_q + 1'b1;
               if (last_addr) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         n_q      <= '0;
         words_q  <= '0;
         addr_q   <= '0;
         beat_q   <= '0;
         data_y_q <= '0;
         data_g_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         words_q  <= words_d;
         addr_q   <= addr_d;
         beat_q   <= beat_d;
         data_y_q <= data_y_d;
         data_g_q <= data_g_d;
         valid_q  <= valid_d;
      end
   end

   assign bram.o_addr_y = {4{addr_q}};
   assign bram.o_addr_g = {4{addr_q}};
   assign bram.o_en_y   = rd_en;
   assign bram.o_en_g   = rd_en;

   assign o_data_y    = data_y_q;
   assign o_data_g    = data_g_q;
   assign o_valid     = beat_out;
   assign o_done      = done;
   assign o_n         = (state_q == ST_IDLE) ? '0 : n_q;
   assign o_dbg_state = state_q;
endmodule

// File: doc/monox_result_drain.md
# monox_result_drain

Read-side drain for the yellow and green monox result buffers. After a monox pass has written its 4-lane results into the banked result BRAMs, this block reads both groups back in lockstep, one word per lane per cycle. It presents the data as a 4-lane stream with `o_n` for the next pass's c1 input port. It is the reader counterpart of the yellow/green write interface (per-lane address, 4-bank result memories).

## Interface
Parameters:
- `DATA_WIDTH`, 64, bits per lane coefficient
- `INDEX_WIDTH`, 13, inner index width
- `ADDR_WIDTH`, `INDEX_WIDTH-1`, per-bank address width
- `BRAM_READ_LATENCY`, 2, cycles from `o_en_*` to valid `i_data_*`
- `POWER_WIDTH`, 4, width of the power-of-2 length field

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `i_en`  in  1  global enable; low freezes all state
- `i_start`  in  1  start pulse; sampled only in IDLE
- `i_n`  in  `POWER_WIDTH`  log2 of coefficient count, captured on start
- `o_addr_y`  out  `4*ADDR_WIDTH`  per-lane read addresses, yellow banks (lane k = bits [k*ADDR_WIDTH +: ADDR_WIDTH])
- `o_addr_g`  out  `4*ADDR_WIDTH`  per-lane read addresses, green banks
- `o_en_y`  out  1  read enable, yellow banks
- `o_en_g`  out  1  read enable, green banks
- `i_data_y`  in  `4*DATA_WIDTH`  yellow read data
- `i_data_g`  in  `4*DATA_WIDTH`  green read data
- `o_data_y`  out  `4*DATA_WIDTH`  registered yellow output beat
- `o_data_g`  out  `4*DATA_WIDTH`  registered green output beat
- `o_valid`  out  1  output beat valid
- `o_n`  out  `POWER_WIDTH`  captured `n` while busy, 0 in IDLE
- `o_done`  out  1  one-cycle pulse coincident with last valid beat

## Operation
- Word count: `W = max(1, (1<<n_eff) >> 2)`, where `n_eff = min(i_n, ADDR_WIDTH+2)`. `W` is held in an `ADDR_WIDTH+1`-bit register.
- FSM states:
  - IDLE: on `i_start & i_en`, capture `n_eff`, clear the address and beat counters, go to READ.
  - READ: on each `i_en` cycle, assert `o_en_y`/`o_en_g` at the current address and increment the address. After issuing address `W-1`, go to DRAIN.
  - DRAIN: no reads. Wait until beat `W-1` leaves the output register, then go to IDLE.
- All four lanes, in both groups, carry the same address.
- Valid tracking: a `BRAM_READ_LATENCY`-deep shift register carries the read-enable bit. When its tail is set, `i_data_*` is loaded into the output register and `o_valid` is set next cycle.
- Beat counter increments on each `o_valid`. `o_done = o_valid & (beat == W-1)`.
- When `i_en` is low:
  - state, counters and the valid pipe hold;
  - `o_en_*` = 0 and `o_valid` = 0;
  - the external BRAM holds its output register while its enable is low.
- `i_start` in READ or DRAIN is ignored.
- `rst` mid-operation: immediate return to IDLE, all outputs 0, no `o_done`.
- Reset value of every output is 0.

## Timing
- `i_start` sampled at edge 0 → `o_en_*` high with address 0 in cycle 1. Addresses then run 0..W-1 over cycles 1..W (no `i_en` stalls).
- Beat for address `a`: `o_valid` in cycle `a + 2 + BRAM_READ_LATENCY`.
- `o_done` in cycle `W + 1 + BRAM_READ_LATENCY`. IDLE is re-entered on the following edge, so a new `i_start` is accepted the cycle after `o_done`.
- `o_n` is valid from cycle 1 through the `o_done` cycle.
- Each `i_en`-low cycle adds exactly one cycle to all subsequent events.

## Structure
- Shared package `monox_pkg` holds:
  - the state enum (IDLE/READ/DRAIN);
  - the `W` computation function;
  - the `n_eff` saturation constant `ADDR_WIDTH+2`.
- One sub-module, `monox_valid_pipe`: a parameterized-depth enable-gated shift register used for read-latency tracking.
- Counters, FSM and output registers live in the top module.

## Test plan
- `i_n=4`, BRAM model returns `{addr,lane}` → addresses 0..3 in cycles 1..4; beats in cycles 4..7 with data 0..3 per lane in both groups; `o_done` in cycle 7; `o_n=4` throughout.
- `i_n=0` → `W=1`: single read at address 0 in cycle 1, single beat with `o_done` in cycle 4.
- `i_n=15` → saturates to `n_eff=14`: 4096 reads, addresses 0..4095, last beat and `o_done` in cycle 4099.
- `i_n=5`, `i_en` low for 3 cycles at cycle 3 → no `o_en`/`o_valid` during the stall; all later events shift by 3; data order intact; `o_done` in cycle 14.
- `i_start` re-pulsed in cycle 2 of an `n=4` run → ignored; single `o_done` in cycle 7; next start at cycle 8 accepted.
- `rst` asserted in cycle 5 of an `n=6` run → all outputs 0 immediately, no `o_done`; fresh `n=4` start after release behaves as in the first scenario.
